divisor_seq: RTL

Sequential restoring divider, 32-bit dividend by 16-bit divisor, producing a 16-bit quotient and 16-bit remainder. It is the inverse companion of the shift-add multiplier in the datapath: the same St/done start-complete handshake, one quotient bit per clock. It serves the DIV/DIVU-style paths of the processor.

---
 rtl/div_pkg.sv | 15 +
 rtl/divisor_seq_if.sv | 27 ++
 rtl/subtrator.sv | 19 +
 rtl/divisor_seq.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: operand half-width,
// iteration counter width and the controller state encoding.
package div_pkg;

  localparam int DIV_N = 16;
  localparam int CNT_W = $clog2(DIV_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    FIN   = 2'd3
  } div_state_t;

endpackage

// File: rtl/divisor_seq_if.sv
// Start/complete handshake and operand/result bus of the sequential divider.
interface divisor_seq_if
  import div_pkg::*;
#(
  parameter int N = DIV_N
);

  logic             St;
  logic [2*N-1:0]   dvdndo;
  logic [N-1:0]     dvsr;
  logic [N-1:0]     quoc;
  logic [N-1:0]     resto;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output St, dvdndo, dvsr,
    input  quoc, resto, ovf, busy, done
  );

  modport slave (
    input  St, dvdndo, dvsr,
    output quoc, resto, ovf, busy, done
  );

endinterface

// File: rtl/subtrator.sv
// Combinational W-bit subtractor with borrow out; the divider's trial-subtract
// stage, counterpart of the multiplier's adder.
module subtrator #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // One extra bit catches the borrow: it is set exactly when a < b.
  logic [W:0] wide_diff;

  assign wide_diff = {1'b0, a} - {1'b0, b};
  assign diff      = wide_diff[W-1:0];
  assign borrow    = wide_diff[W];

endmodule

// File: rtl/divisor_seq.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per clock, with overflow detection before iterating.
module divisor_seq
  import div_pkg::*;
(
  input logic         clk,
  input logic         rst,
  divisor_seq_if.slave bus
);

  localparam int N = DIV_N;

  div_state_t       state_reg, state_next;
  logic [2*N-1:0]   d_reg, d_next;
  logic [N-1:0]     v_reg, v_next;
  logic [N:0]       r_reg, r_next;
  logic [N-1:0]     q_reg, q_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_flag_reg, ovf_flag_next;
  logic [N-1:0]     quoc_reg, quoc_next;
  logic [N-1:0]     resto_reg, resto_next;
  logic             ovf_reg, ovf_next;
  logic             done_reg, done_next;

  logic [N:0]       s_val;
  logic [N:0]       t_diff;
  logic             t_borrow;

  // Shift the next dividend bit into the partial remainder, then try V.
  assign s_val = {r_reg[N-1:0], q_reg[N-1]};

  subtrator #(.W(N + 1)) u_sub (
    .a      (s_val),
    .b      ({1'b0, v_reg}),
    .diff   (t_diff),
    .borrow (t_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    d_next        = d_reg;
    v_next        = v_reg;
    r_next        = r_reg;
    q_next        = q_reg;
    cnt_next      = cnt_reg;
    ovf_flag_next = ovf_flag_reg;
    quoc_next     = quoc_reg;
    resto_next    = resto_reg;
    ovf_next      = ovf_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.St) begin
          d_next     = bus.dvdndo;
          v_next     = bus.dvsr;
          state_next = CHECK;
        end
      end

      CHECK: begin
        // A high half >= V means the quotient needs more than N bits.
        if (v_reg == '0 || d_reg[2*N-1:N] >= v_reg) begin
          ovf_flag_next = 1'b1;
          state_next    = FIN;
        end else begin
          ovf_flag_next = 1'b0;
          r_next        = {1'b0, d_reg[2*N-1:N]};
          q_next        = d_reg[N-1:0];
          cnt_next      = CNT_W'(N - 1);
          state_next    = ITER;
        end
      end

      ITER: begin
        r_next = t_borrow ? s_val : t_diff;
        q_next = {q_reg[N-2:0], ~t_borrow};
        if (cnt_reg == '0) begin
          state_next = FIN;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      FIN: begin
        if (ovf_flag_reg) begin
          quoc_next  = '1;
          resto_next = d_reg[2*N-1:N];
          ovf_next   = 1'b1;
        end else begin
          quoc_next  = q_reg;
          resto_next = r_reg[N-1:0];
          ovf_next   = 1'b0;
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg        <= '0;
      v_reg        <= '0;
      r_reg        <= '0;
      q_reg        <= '0;
      cnt_reg      <= '0;
      ovf_flag_reg <= 1'b0;
      quoc_reg     <= '0;
      resto_reg    <= '0;
      ovf_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      d_reg        <= d_next;
      v_reg        <= v_next;
      r_reg        <= r_next;
      q_reg        <= q_next;
      cnt_reg      <= cnt_next;
      ovf_flag_reg <= ovf_flag_next;
      quoc_reg     <= quoc_next;
      resto_reg    <= resto_next;
      ovf_reg      <= ovf_next;
      done_reg     <= done_next;
    end
  end

  assign bus.quoc  = quoc_reg;
  assign bus.resto = resto_reg;
  assign bus.ovf   = ovf_reg;
  assign bus.done  = done_reg;
  assign bus.busy  = (state_reg != IDLE);

endmodule
